// File: rtl/ul_tdm_lane_demux.sv
// ul_tdm_lane_demux: uplink TDM serial stream to LANES-wide parallel sample groups.
// Define UL_TDM_LANE_DEMUX_ZERO_IDLE_EN to force o_freq_fdata to 0 between strobes.
module ul_tdm_lane_demux #(
    parameter int DW = 32,
    parameter int SLOTS = 8,
    parameter int LANES = 2,
    localparam int NG = SLOTS / LANES,
    localparam int GW = (NG > 1) ? $clog2(NG) : 1
) (
    input  logic                clk_491,
    input  logic                rst_491,
    input  logic [DW-1:0]       i_freq_fdata,
    input  logic                i_freq_ffram,
    output logic                o_freq_ffram,
    output logic [LANES*DW-1:0] o_freq_fdata,
    output logic                o_freq_fvld,
    output logic [GW-1:0]       o_lane_grp,
    output logic                o_sync_err
);
    localparam int SW = $clog2(SLOTS);
    logic [SW-1:0] slot_q, slot_d;
    logic locked_q, locked_d;
    logic [(LANES-1)*DW-1:0] sr_q, sr_d;
    logic [LANES*DW-1:0] win, fdata_q, fdata_d;
    logic fvld_q, fvld_d, ffram_q, ffram_d, err_q, err_d, grp_end;
    logic [GW-1:0] grp_q, grp_d;
    always_comb begin
        slot_d = (i_freq_ffram || slot_q == SW'(SLOTS - 1)) ? '0 : slot_q + 1'b1;
        locked_d = locked_q | i_freq_ffram;
        win = {i_freq_fdata, sr_q};
        sr_d = win[LANES*DW-1:DW];
        grp_end = locked_d && (int'(slot_d) % LANES == LANES - 1);
        grp_d = grp_end ? GW'(int'(slot_d) / LANES) : grp_q;
        fvld_d = grp_end;
        ffram_d = grp_end && (int'(slot_d) / LANES == 0);
        err_d = i_freq_ffram && locked_q && slot_q != SW'(SLOTS - 1);
`ifdef UL_TDM_LANE_DEMUX_ZERO_IDLE_EN
        fdata_d = grp_end ? win : '0;
`else
        fdata_d = grp_end ? win : fdata_q;
`endif
    end
    always_ff @(posedge clk_491) begin
        if (rst_491) begin
            slot_q   <= SW'(SLOTS - 1);
            locked_q <= 1'b0;
            sr_q     <= '0;
            fdata_q  <= '0;
            fvld_q   <= 1'b0;
            ffram_q  <= 1'b0;
            grp_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            locked_q <= locked_d;
            sr_q     <= sr_d;
            fdata_q  <= fdata_d;
            fvld_q   <= fvld_d;
            ffram_q  <= ffram_d;
            grp_q    <= grp_d;
            err_q    <= err_d;
        end
    end
    assign o_freq_fdata = fdata_q;
    assign o_freq_fvld  = fvld_q;
    assign o_freq_ffram = ffram_q;
    assign o_lane_grp   = grp_q;
    assign o_sync_err   = err_q;
endmodule

// File: tb/tb_ul_tdm_lane_demux.sv
// tb_ul_tdm_lane_demux: vector table, directed corner sequences and randomized model comparison.
module tb_ul_tdm_lane_demux;
    localparam int DW = 32, S = 8, L = 2;
`ifdef UL_TDM_LANE_DEMUX_ZERO_IDLE_EN
    localparam bit ZI = 1'b1;
`else
    localparam bit ZI = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, fr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [2*DW-1:0] fd_a;
    logic vld_a, fro_a, err_a;
    logic [1:0] grp_a;
    logic [4*DW-1:0] fd_b;
    logic vld_b, fro_b, err_b;
    logic [0:0] grp_b;
    int checks = 0, errors = 0;
    int m_slot = S - 1;
    bit m_locked = 1'b0;
    logic [DW-1:0] m_buf [S];
    logic [2*DW-1:0] e_fd = '0;
    bit e_vld = 0, e_fr = 0, e_err = 0;
    int e_grp = 0;

    always #5 clk = ~clk;

    ul_tdm_lane_demux #(.DW(DW), .SLOTS(S), .LANES(L)) dut_a (
        .clk_491(clk), .rst_491(rst), .i_freq_fdata(din), .i_freq_ffram(fr),
        .o_freq_ffram(fro_a), .o_freq_fdata(fd_a), .o_freq_fvld(vld_a),
        .o_lane_grp(grp_a), .o_sync_err(err_a));

    ul_tdm_lane_demux #(.DW(DW), .SLOTS(S), .LANES(4)) dut_b (
        .clk_491(clk), .rst_491(rst), .i_freq_fdata(din), .i_freq_ffram(fr),
        .o_freq_ffram(fro_b), .o_freq_fdata(fd_b), .o_freq_fvld(vld_b),
        .o_lane_grp(grp_b), .o_sync_err(err_b));

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    // Reference: slot numbering and grouping by period position, for the LANES=2 instance.
    task automatic model(input bit r, input bit f, input logic [DW-1:0] d);
        int s;
        if (r) begin
            m_slot = S - 1; m_locked = 0;
            e_fd = '0; e_vld = 0; e_fr = 0; e_err = 0; e_grp = 0;
            return;
        end
        s = f ? 0 : (m_slot + 1) % S;
        e_err = f && m_locked && m_slot != S - 1;
        m_locked = m_locked || f;
        m_buf[s] = d;
        if (m_locked && s % L == L - 1) begin
            for (int k = 0; k < L; k++) e_fd[k*DW +: DW] = m_buf[s-L+1+k];
            e_vld = 1; e_grp = s / L; e_fr = (s / L == 0);
        end else begin
            e_vld = 0; e_fr = 0;
            if (ZI) e_fd = '0;
        end
        m_slot = s;
    endtask

    task automatic step(input bit r, input bit f, input logic [DW-1:0] d);
        rst = r; fr = f; din = d;
        model(r, f, d);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit fr;
        logic [DW-1:0] d;
        bit vld;
        bit fro;
        int grp;
        logic [2*DW-1:0] fd;
    } vec_t;
    vec_t tbl [12];

    initial begin
        logic [2*DW-1:0] last;
        logic [4*DW-1:0] g4;
        tbl[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 0, 64'h0};
        tbl[1]  = '{1'b0, 32'h101, 1'b1, 1'b1, 0, 64'h00000101_00000100};
        tbl[2]  = '{1'b0, 32'h102, 1'b0, 1'b0, 0, 64'h0};
        tbl[3]  = '{1'b0, 32'h103, 1'b1, 1'b0, 1, 64'h00000103_00000102};
        tbl[4]  = '{1'b0, 32'h104, 1'b0, 1'b0, 1, 64'h0};
        tbl[5]  = '{1'b0, 32'h105, 1'b1, 1'b0, 2, 64'h00000105_00000104};
        tbl[6]  = '{1'b0, 32'h106, 1'b0, 1'b0, 2, 64'h0};
        tbl[7]  = '{1'b0, 32'h107, 1'b1, 1'b0, 3, 64'h00000107_00000106};
        tbl[8]  = '{1'b0, 32'h108, 1'b0, 1'b0, 3, 64'h0};
        tbl[9]  = '{1'b0, 32'h109, 1'b1, 1'b1, 0, 64'h00000109_00000108};
        tbl[10] = '{1'b0, 32'h10a, 1'b0, 1'b0, 0, 64'h0};
        tbl[11] = '{1'b0, 32'h10b, 1'b1, 1'b0, 1, 64'h0000010b_0000010a};

        step(1, 1, 32'hdead);
        step(1, 0, 32'h0);
        chk("reset_state", {fd_a, vld_a, fro_a, grp_a, err_a}, '0);

        // ffram during reset must not lock; unlocked stream stays silent
        for (int c = 0; c < 20; c++) begin
            step(0, 0, $urandom);
            chk("unlocked_quiet", {fd_a, vld_a, fro_a, grp_a, err_a}, '0);
        end

        step(1, 0, 0);
        last = '0;
        for (int i = 0; i < 12; i++) begin
            step(0, tbl[i].fr, tbl[i].d);
            if (tbl[i].vld) last = tbl[i].fd;
            chk($sformatf("tbl_vld%0d", i), vld_a, tbl[i].vld);
            chk($sformatf("tbl_ffram%0d", i), fro_a, tbl[i].fro);
            chk($sformatf("tbl_grp%0d", i), grp_a, tbl[i].grp);
            chk($sformatf("tbl_fdata%0d", i), fd_a, ZI && !tbl[i].vld ? '0 : last);
            chk($sformatf("tbl_err%0d", i), err_a, 0);
        end

        step(1, 0, 0);
        for (int c = 0; c < 8; c++) begin
            step(0, c == 0 || c == 5, 32'h200 + c);
            chk($sformatf("early_err%0d", c), err_a, c == 5);
            chk($sformatf("early_vld%0d", c), vld_a, c == 1 || c == 3 || c == 6);
            if (c == 3) chk("early_g1", {fd_a, grp_a}, {64'h00000203_00000202, 2'd1});
            if (c == 6) chk("early_g0", {fd_a, grp_a, fro_a}, {64'h00000206_00000205, 2'd0, 1'b1});
        end

        step(1, 0, 0);
        for (int c = 0; c < 5; c++) step(0, c == 0, 32'h300 + c);
        step(1, 0, 32'h305);
        chk("midrst_zero", {fd_a, vld_a, fro_a, grp_a, err_a}, '0);
        for (int c = 6; c < 9; c++) begin
            step(0, 0, 32'h300 + c);
            chk($sformatf("midrst_quiet%0d", c), vld_a, 0);
        end
        step(0, 1, 32'h309);
        chk("relock_c9", vld_a, 0);
        step(0, 0, 32'h30a);
        chk("relock_c10", {fd_a, vld_a, fro_a, grp_a}, {64'h0000030a_00000309, 1'b1, 1'b1, 2'd0});

        step(1, 0, 0);
        for (int c = 0; c < 8; c++) begin
            step(0, c == 0, 32'h100 + c);
            if (c == 3) begin
                g4 = {32'h103, 32'h102, 32'h101, 32'h100};
                chk("l4_g0", {fd_b, vld_b, fro_b, grp_b}, {g4, 1'b1, 1'b1, 1'b0});
            end
            if (c == 4) chk("l4_idle", {fd_b, vld_b}, {ZI ? 128'h0 : g4, 1'b0});
            if (c == 7) chk("l4_g1", {fd_b, vld_b, fro_b, grp_b},
                            {32'h107, 32'h106, 32'h105, 32'h104, 1'b1, 1'b0, 1'b1});
            if (c != 3 && c != 7) chk($sformatf("l4_vld%0d", c), vld_b, 0);
        end

        for (int c = 0; c < 600; c++) begin
            bit r, f;
            r = $urandom_range(0, 79) == 0;
            f = (m_slot == S - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 14) == 0);
            step(r, f, $urandom);
            chk("rnd_vld", vld_a, e_vld);
            chk("rnd_ffram", fro_a, e_fr);
            chk("rnd_grp", grp_a, e_grp);
            chk("rnd_fdata", fd_a, e_fd);
            chk("rnd_err", err_a, e_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
